// File: rtl/dram_fifo_ctrl_pkg.sv
// rtl/dram_fifo_ctrl_pkg.sv - shared sizing helpers for the LUT-RAM FIFO controller
package dram_fifo_ctrl_pkg;

  // Number of words held by the LUT-RAM array for a given address width.
  function automatic int depth_of(input int aw);
    return 1 << aw;
  endfunction

  // Pointer/occupancy width: one extra wrap bit above the address.
  function automatic int cnt_w(input int aw);
    return aw + 1;
  endfunction

  // Only the native LUT-RAM primitive depths (32 and 64) are supported.
  function automatic bit aw_legal(input int aw);
    return (aw == 5) || (aw == 6);
  endfunction

endpackage

// File: rtl/ram_sxp.sv
// rtl/ram_sxp.sv - LUT-RAM array, synchronous write, asynchronous read
module ram_sxp
  import dram_fifo_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_WIDTH  = 5,
  parameter int ULTRA_SCALE = 0,
  parameter int MODE_SDP    = 1
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int DEPTH = depth_of(ADDR_WIDTH);

  // Only the simple-dual-port flavour exists in this array.
  if (MODE_SDP != 1) begin : g_bad_mode
    $error("ram_sxp: only MODE_SDP=1 is implemented");
  end

  // Primitive family select must be 7-series (0) or UltraScale (1).
  if ((ULTRA_SCALE != 0) && (ULTRA_SCALE != 1)) begin : g_bad_family
    $error("ram_sxp: ULTRA_SCALE must be 0 or 1");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Write port; the array has no reset, validity is tracked by the controller.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/dram_fifo_ctrl.sv
// rtl/dram_fifo_ctrl.sv - FIFO controller around a LUT-RAM with registered output stage
module dram_fifo_ctrl
  import dram_fifo_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH   = 16,
  parameter int ADDR_WIDTH   = 5,
  parameter int ULTRA_SCALE  = 0,
  parameter int AFULL_THRESH = 24
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH:0]   used,
  output logic                  afull
);

  localparam int DEPTH = depth_of(ADDR_WIDTH);
  localparam int CNT_W = cnt_w(ADDR_WIDTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AFULL_C = CNT_W'(AFULL_THRESH);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  if (!aw_legal(ADDR_WIDTH)) begin : g_bad_aw
    $error("dram_fifo_ctrl: ADDR_WIDTH must be 5 or 6");
  end

  // Threshold may equal DEPTH+1 because the output register adds one slot.
  if ((AFULL_THRESH < 1) || (AFULL_THRESH > DEPTH + 1)) begin : g_bad_afull
    $error("dram_fifo_ctrl: AFULL_THRESH must be within 1..DEPTH+1");
  end

  logic [CNT_W-1:0]      wptr, rptr;
  logic [CNT_W-1:0]      wptr_nxt, rptr_nxt;
  logic [CNT_W-1:0]      ram_cnt, ram_cnt_nxt, used_nxt;
  logic                  out_valid_nxt;
  logic                  afull_nxt;
  logic                  init_done;
  logic                  wr_en, load;
  logic [DATA_WIDTH-1:0] rdata;

  // Wrap bit makes full (DEPTH) and empty (0) distinguishable by subtraction.
  assign ram_cnt  = wptr - rptr;
  assign in_ready = init_done & (ram_cnt != DEPTH_C);
  // A flushed write is dropped before it reaches the array.
  assign wr_en    = in_valid & in_ready & ~flush;
  // The output register refills whenever it is empty or being drained; a word
  // written this cycle is not yet counted in ram_cnt, so there is no bypass.
  assign load     = (ram_cnt != '0) & (~out_valid | out_ready);
  assign used     = ram_cnt + {{ADDR_WIDTH{1'b0}}, out_valid};

  // Next pointer/valid state, used both for the registers and the afull look-ahead.
  always_comb begin
    wptr_nxt      = wptr;
    rptr_nxt      = rptr;
    out_valid_nxt = out_valid;
    if (flush) begin
      wptr_nxt      = '0;
      rptr_nxt      = '0;
      out_valid_nxt = 1'b0;
    end else begin
      if (wr_en) begin
        wptr_nxt = wptr + ONE_C;
      end
      if (load) begin
        rptr_nxt      = rptr + ONE_C;
        out_valid_nxt = 1'b1;
      end else if (out_valid & out_ready) begin
        out_valid_nxt = 1'b0;
      end
    end
    ram_cnt_nxt = wptr_nxt - rptr_nxt;
    used_nxt    = ram_cnt_nxt + {{ADDR_WIDTH{1'b0}}, out_valid_nxt};
    afull_nxt   = ~flush & (used_nxt >= AFULL_C);
  end

  // Control registers; out_data keeps its last word when drained or flushed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr      <= '0;
      rptr      <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      afull     <= 1'b0;
      init_done <= 1'b0;
    end else begin
      wptr      <= wptr_nxt;
      rptr      <= rptr_nxt;
      out_valid <= out_valid_nxt;
      afull     <= afull_nxt;
      init_done <= 1'b1;
      if (load & ~flush) begin
        out_data <= rdata;
      end
    end
  end

  ram_sxp #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .ULTRA_SCALE(ULTRA_SCALE),
    .MODE_SDP   (1)
  ) u_ram (
    .clk  (clk),
    .we   (wr_en),
    .waddr(wptr[ADDR_WIDTH-1:0]),
    .wdata(in_data),
    .raddr(rptr[ADDR_WIDTH-1:0]),
    .rdata(rdata)
  );

endmodule
